// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALUOp codes and FSM state encoding.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_ILLEGAL
    } state_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Opcode decoder: produces the per-class CPU_EU control bundle and instruction class flags.
module cpu_ctrl_decode
    import cpu_defs::*;
(
    input  logic [5:0] opcode_i,
    output logic       reg_dst_o,
    output logic       alu_src_o,
    output logic [1:0] alu_op_o,
    output logic       mem_to_reg_o,
    output logic       is_mem_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       illegal_o
);

    always_comb begin
        reg_dst_o    = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = ALUOP_ADD;
        mem_to_reg_o = 1'b0;
        is_mem_o     = 1'b0;
        is_store_o   = 1'b0;
        is_branch_o  = 1'b0;
        is_jump_o    = 1'b0;
        illegal_o    = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                reg_dst_o = 1'b1;
                alu_op_o  = ALUOP_FUNCT;
            end
            OP_LW: begin
                alu_src_o    = 1'b1;
                mem_to_reg_o = 1'b1;
                is_mem_o     = 1'b1;
            end
            OP_SW: begin
                alu_src_o  = 1'b1;
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
            end
            OP_BEQ: begin
                alu_op_o    = ALUOP_SUB;
                is_branch_o = 1'b1;
            end
            OP_ADDI: alu_src_o = 1'b1;
            OP_J:    is_jump_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: owns PC/IR, sequences FETCH-DECODE-EXEC-MEM-WB and drives CPU_EU controls.
module cpu_control_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Instr_Address,
    input  logic [31:0] Instr_Data,
    output logic [25:0] Instruction,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        RegWrite,
    output logic        MemtoReg,
    input  logic        Zero,
    input  logic [31:0] SEImm,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic        Mem_Ready,
    output logic [31:0] PC,
    output logic        Illegal
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic        ctrl_active;

    logic       dec_reg_dst, dec_alu_src, dec_mem_to_reg;
    logic [1:0] dec_alu_op;
    logic       dec_is_mem, dec_is_store, dec_is_branch, dec_is_jump, dec_illegal;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    cpu_ctrl_decode u_decode (
        .opcode_i     (ir_q[31:26]),
        .reg_dst_o    (dec_reg_dst),
        .alu_src_o    (dec_alu_src),
        .alu_op_o     (dec_alu_op),
        .mem_to_reg_o (dec_mem_to_reg),
        .is_mem_o     (dec_is_mem),
        .is_store_o   (dec_is_store),
        .is_branch_o  (dec_is_branch),
        .is_jump_o    (dec_is_jump),
        .illegal_o    (dec_illegal)
    );

    // Shifting the full 32-bit SEImm drops its top two bits, matching SEImm[29:0]<<2.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + (SEImm << 2);
    assign jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        illegal_d   = illegal_q;
        ctrl_active = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = Instr_Data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_ILLEGAL;
                end else if (dec_is_jump) begin
                    pc_d    = jump_target;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ctrl_active = 1'b1;
                if (dec_is_branch) begin
                    pc_d    = Zero ? branch_target : pc_plus4;
                    state_d = ST_FETCH;
                end else if (dec_is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                ctrl_active = 1'b1;
                MemRead     = ~dec_is_store;
                MemWrite    = dec_is_store;
                if (Mem_Ready) begin
                    if (dec_is_store) begin
                        pc_d    = pc_plus4;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                ctrl_active = 1'b1;
                RegWrite    = 1'b1;
                pc_d        = pc_plus4;
                state_d     = ST_FETCH;
            end
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // The bundle is gated so it reads 0 in FETCH/DECODE/ILLEGAL and holds steady from EXEC on.
    assign RegDst        = ctrl_active & dec_reg_dst;
    assign ALUSrc        = ctrl_active & dec_alu_src;
    assign ALUOp         = ctrl_active ? dec_alu_op : ALUOP_ADD;
    assign MemtoReg      = ctrl_active & dec_mem_to_reg;
    assign Instruction   = ir_q[25:0];
    assign Instr_Address = pc_q;
    assign PC            = pc_q;
    assign Illegal       = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed scenarios plus randomized instruction streams.
module tb_cpu_control_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_Address;
    logic [31:0] Instr_Data;
    logic [25:0] Instruction;
    logic        RegDst, ALUSrc, RegWrite, MemtoReg;
    logic [1:0]  ALUOp;
    logic        Zero;
    logic [31:0] SEImm;
    logic        MemRead, MemWrite, Mem_Ready;
    logic [31:0] PC;
    logic        Illegal;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    cpu_control_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .Instr_Address (Instr_Address),
        .Instr_Data    (Instr_Data),
        .Instruction   (Instruction),
        .RegDst        (RegDst),
        .ALUSrc        (ALUSrc),
        .ALUOp         (ALUOp),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .Zero          (Zero),
        .SEImm         (SEImm),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Mem_Ready     (Mem_Ready),
        .PC            (PC),
        .Illegal       (Illegal)
    );

    // Control bundle {RegDst, ALUSrc, ALUOp, MemtoReg} per instruction class.
    function automatic logic [4:0] class_bundle(input logic [5:0] op);
        case (op)
            6'b000000: return 5'b1_0_10_0;
            6'b100011: return 5'b0_1_00_1;
            6'b101011: return 5'b0_1_00_0;
            6'b000100: return 5'b0_0_01_0;
            6'b001000: return 5'b0_1_00_0;
            default:   return 5'b0;
        endcase
    endfunction

    function automatic logic rand_bit();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_pc  = RST_PC;
    endtask

    // One instruction, cycle by cycle, against the schedule implied by its class.
    task automatic run_instr(input logic [31:0] instr, input int waits,
                             input logic zero_x, input logic [31:0] seimm_x);
        logic [5:0]  op;
        logic [31:0] pc4, nxt;
        logic [7:0]  exp_v, got_v;
        logic        is_mem, has_wb, in_mem;
        int          len;
        op     = instr[31:26];
        is_mem = (op == 6'b100011) || (op == 6'b101011);
        has_wb = (op == 6'b000000) || (op == 6'b001000) || (op == 6'b100011);
        case (op)
            6'b000010: len = 2;
            6'b000100: len = 3;
            6'b101011: len = 4 + waits;
            6'b100011: len = 5 + waits;
            default:   len = 4;
        endcase
        for (int k = 0; k < len; k++) begin
            Instr_Data = (k == 0) ? instr : $urandom;
            Zero       = (k == 2) ? zero_x : rand_bit();
            SEImm      = (k == 2) ? seimm_x : $urandom;
            in_mem     = is_mem && (k >= 3) && (k <= 3 + waits);
            Mem_Ready  = in_mem ? (k == 3 + waits) : rand_bit();
            #1;
            exp_v = {(k >= 2) ? class_bundle(op) : 5'b0, has_wb && (k == len - 1),
                     in_mem && (op == 6'b100011), in_mem && (op == 6'b101011)};
            got_v = {RegDst, ALUSrc, ALUOp, MemtoReg, RegWrite, MemRead, MemWrite};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL ctrl op=%b cycle=%0d got=%b expected=%b", op, k, got_v, exp_v);
            end
            n_checks++;
            if (PC !== m_pc || Instr_Address !== m_pc || Illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL pc op=%b cycle=%0d PC=%h addr=%h ill=%b expected PC=%h ill=0",
                         op, k, PC, Instr_Address, Illegal, m_pc);
            end
            if (k >= 1) begin
                n_checks++;
                if (Instruction !== instr[25:0]) begin
                    n_fail++;
                    $display("FAIL ir cycle=%0d got=%h expected=%h", k, Instruction, instr[25:0]);
                end
            end
            @(posedge clk); #1;
        end
        pc4 = m_pc + 32'd4;
        if (op == 6'b000010)      nxt = {pc4[31:28], instr[25:0], 2'b00};
        else if (op == 6'b000100) nxt = zero_x ? pc4 + seimm_x * 32'd4 : pc4;
        else                      nxt = pc4;
        m_pc = nxt;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        run_instr(32'h1000_0000, 0, 1'b1, (target - (m_pc + 32'd4)) >> 2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Instr_Data = $urandom; Zero = rand_bit(); SEImm = $urandom; Mem_Ready = rand_bit();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc  = RST_PC;
        n_checks++;
        if ({RegDst, ALUSrc, ALUOp, MemtoReg, RegWrite, MemRead, MemWrite} !== 8'b0 ||
            PC !== RST_PC || Instr_Address !== RST_PC || Illegal !== 1'b0 || Instruction !== 26'd0) begin
            n_fail++;
            $display("FAIL reset PC=%h addr=%h ill=%b ir=%h ctl=%b expected PC=%h, rest 0",
                     PC, Instr_Address, Illegal, Instruction,
                     {RegDst, ALUSrc, ALUOp, MemtoReg, RegWrite, MemRead, MemWrite}, RST_PC);
        end
    endtask

    task automatic test_rtype();
        run_instr(32'h0000_0000, 0, 1'b0, 32'd0);
        n_checks++;
        if (PC !== 32'h104) begin
            n_fail++;
            $display("FAIL sll_pc got=%h expected=%h", PC, 32'h104);
        end
        run_instr(32'h0000_F827, 0, rand_bit(), $urandom);
        run_instr({6'b001000, 26'($urandom)}, 0, rand_bit(), $urandom);
        n_checks++;
        if (PC !== 32'h10C) begin
            n_fail++;
            $display("FAIL rtype_pc got=%h expected=%h", PC, 32'h10C);
        end
    endtask

    task automatic test_mem_wait();
        run_instr(32'h8C05_0004, 3, rand_bit(), $urandom);
        run_instr({6'b101011, 26'($urandom)}, 2, rand_bit(), $urandom);
        run_instr({6'b101011, 26'($urandom)}, 0, rand_bit(), $urandom);
        run_instr({6'b100011, 26'($urandom)}, 0, rand_bit(), $urandom);
        n_checks++;
        if (PC !== 32'h11C) begin
            n_fail++;
            $display("FAIL mem_pc got=%h expected=%h", PC, 32'h11C);
        end
    endtask

    task automatic test_branch_jump();
        run_instr({6'b000010, 26'h8}, 0, rand_bit(), $urandom);
        run_instr(32'h1085_0003, 0, 1'b1, 32'd3);
        n_checks++;
        if (PC !== 32'h30) begin
            n_fail++;
            $display("FAIL beq_taken got=%h expected=%h", PC, 32'h30);
        end
        run_instr({6'b000010, 26'h8}, 0, rand_bit(), $urandom);
        run_instr(32'h1085_0003, 0, 1'b0, 32'd3);
        n_checks++;
        if (PC !== 32'h24) begin
            n_fail++;
            $display("FAIL beq_not_taken got=%h expected=%h", PC, 32'h24);
        end
        goto_pc(32'h1000_0000);
        run_instr({6'b000010, 26'h40}, 0, rand_bit(), $urandom);
        n_checks++;
        if (PC !== 32'h1000_0100) begin
            n_fail++;
            $display("FAIL jump got=%h expected=%h", PC, 32'h1000_0100);
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        run_instr(32'h0000_0020, 0, rand_bit(), $urandom);
        n_checks++;
        if (PC !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap got=%h expected=%h", PC, 32'h0);
        end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 22; k++) begin
            Instr_Data = (k == 0) ? {6'b111111, 26'($urandom)} : $urandom;
            Zero = rand_bit(); SEImm = $urandom; Mem_Ready = rand_bit();
            #1;
            n_checks++;
            if (Illegal !== (k >= 2) || PC !== m_pc ||
                {RegDst, ALUSrc, ALUOp, MemtoReg, RegWrite, MemRead, MemWrite} !== 8'b0) begin
                n_fail++;
                $display("FAIL illegal cycle=%0d ill=%b PC=%h ctl=%b expected ill=%b PC=%h ctl=0",
                         k, Illegal, PC, {RegDst, ALUSrc, ALUOp, MemtoReg, RegWrite, MemRead, MemWrite},
                         k >= 2, m_pc);
            end
            @(posedge clk); #1;
        end
        do_reset();
        n_checks++;
        if (Illegal !== 1'b0 || PC !== RST_PC) begin
            n_fail++;
            $display("FAIL illegal_reset ill=%b PC=%h expected ill=0 PC=%h", Illegal, PC, RST_PC);
        end
    endtask

    task automatic test_reset_mid_mem();
        run_instr(32'h0000_0000, 0, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            Instr_Data = (k == 0) ? {6'b101011, 26'($urandom)} : $urandom;
            Mem_Ready = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++;
        if (MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_in_mem MemWrite=%b expected=1", MemWrite);
        end
        do_reset();
        n_checks++;
        if (MemWrite !== 1'b0 || MemRead !== 1'b0 || RegWrite !== 1'b0 || Illegal !== 1'b0 || PC !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_mid_mem mw=%b mr=%b rw=%b ill=%b PC=%h expected 0,0,0,0,%h",
                     MemWrite, MemRead, RegWrite, Illegal, PC, RST_PC);
        end
        run_instr(32'h0000_F827, 0, 1'b0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(5, 0)];
            run_instr({op, 26'($urandom)}, int'($urandom_range(3, 0)), rand_bit(), $urandom);
        end
        Instr_Data = 32'h0; Mem_Ready = 1'b0;
        #1;
        n_checks++;
        if (PC !== m_pc) begin
            n_fail++;
            $display("FAIL random_final_pc got=%h expected=%h", PC, m_pc);
        end
    endtask

    initial begin
        reset = 1'b1; Instr_Data = 32'd0; Zero = 1'b0; SEImm = 32'd0; Mem_Ready = 1'b0;
        m_pc = RST_PC;
        test_reset();
        test_rtype();
        test_mem_wait();
        test_branch_jump();
        test_wrap();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
